// File: rtl/cnn_pkg.sv
// Shared types and sizing for the CNN sliding-window generator.
// Latency: n/a (package).
// Backpressure: n/a (package).
//
// Holds pixel/window types, the window-generator state enum, and helpers
// that clamp a requested frame dimension into the legal range K..MAX.
package cnn_pkg;

    localparam int DATA_W    = 16;
    localparam int K         = 5;
    localparam int IMG_W_MAX = 32;
    localparam int IMG_H_MAX = 32;

    localparam int DIM_W_W = $clog2(IMG_W_MAX + 1);  // img_w port width
    localparam int DIM_H_W = $clog2(IMG_H_MAX + 1);  // img_h port width
    localparam int COL_W   = $clog2(IMG_W_MAX);      // column counter / line-buffer address
    localparam int ROW_W   = $clog2(IMG_H_MAX);      // row counter

    typedef logic signed [DATA_W-1:0] pixel_t;
    typedef pixel_t window_t [K][K];

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } wingen_state_e;

    // Clamp a requested width to K..IMG_W_MAX and return the last column index.
    function automatic logic [COL_W-1:0] last_col(input logic [DIM_W_W-1:0] w);
        logic [DIM_W_W-1:0] v;
        if (w < DIM_W_W'(K))              v = DIM_W_W'(K);
        else if (w > DIM_W_W'(IMG_W_MAX)) v = DIM_W_W'(IMG_W_MAX);
        else                              v = w;
        v = v - DIM_W_W'(1);
        return v[COL_W-1:0];
    endfunction

    // Clamp a requested height to K..IMG_H_MAX and return the last row index.
    function automatic logic [ROW_W-1:0] last_row(input logic [DIM_H_W-1:0] h);
        logic [DIM_H_W-1:0] v;
        if (h < DIM_H_W'(K))              v = DIM_H_W'(K);
        else if (h > DIM_H_W'(IMG_H_MAX)) v = DIM_H_W'(IMG_H_MAX);
        else                              v = h;
        v = v - DIM_H_W'(1);
        return v[ROW_W-1:0];
    endfunction

endpackage

// File: rtl/cnn_line_buffer.sv
// One feature-map row of storage, depth IMG_W_MAX, one read + one write at the same address.
// Latency: read is combinational; a write lands on the next rising edge (read-before-write).
// Backpressure: none; the caller gates we_i with its own handshake.
//
// Ports:
//   clk_i   clock
//   we_i    write enable (pixel accepted this cycle)
//   addr_i  column address shared by read and write
//   wdat_i  pixel written at addr_i
//   rdat_o  pixel currently stored at addr_i (old value during a write)
// Contents are not reset; every location is written before it is ever used.
module cnn_line_buffer
    import cnn_pkg::*;
(
    input  logic               clk_i,
    input  logic               we_i,
    input  logic [COL_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]  wdat_i,
    output logic [DATA_W-1:0]  rdat_o
);

    pixel_t mem_q [IMG_W_MAX];

    assign rdat_o = mem_q[addr_i];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdat_i;
        end
    end

endmodule

// File: rtl/cnn_window_gen.sv
// KxK sliding-window generator: raster pixel stream in, every KxK window out in raster order.
// Latency: a window appears 1 cycle after the pixel that completes it is accepted.
// Backpressure: in_ready_o drops while a window is held unaccepted; 1 pixel/cycle otherwise.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   start_i                frame start pulse; latches img_w_i/img_h_i (clamped) when idle
//   img_w_i, img_h_i       frame dimensions
//   in_valid_i/in_ready_o  pixel handshake, in_data_i pixel
//   win_valid_o/win_ready_i window handshake; win_data_o packed window, element (i,j) at
//                          [(i*K+j)*DATA_W +: DATA_W]; win_row_o/win_col_o window origin
//   done_o                 one-cycle pulse when the frame is fully drained
//   cfg_stride2_i          only with CNN_WINGEN_STRIDE2_EN: emit even-origin windows only
// Optional build macro: CNN_WINGEN_STRIDE2_EN (adds cfg_stride2_i, latched on start).
module cnn_window_gen
    import cnn_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic [DIM_W_W-1:0]     img_w_i,
    input  logic [DIM_H_W-1:0]     img_h_i,
`ifdef CNN_WINGEN_STRIDE2_EN
    input  logic                   cfg_stride2_i,
`endif
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [DATA_W-1:0]      in_data_i,
    output logic                   win_valid_o,
    input  logic                   win_ready_i,
    output logic [K*K*DATA_W-1:0]  win_data_o,
    output logic [ROW_W-1:0]       win_row_o,
    output logic [COL_W-1:0]       win_col_o,
    output logic                   done_o
);

    wingen_state_e     state_q;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  h_last_q;
    logic [COL_W-1:0]  w_last_q;
    window_t           win_q;
    logic              win_valid_q;
    logic [ROW_W-1:0]  win_row_q;
    logic [COL_W-1:0]  win_col_q;
    logic              done_q;
`ifdef CNN_WINGEN_STRIDE2_EN
    logic              stride2_q;
`endif

    logic              accept;
    logic              last_px;
    logic              emit_ok;
    logic [ROW_W-1:0]  org_row;
    logic [COL_W-1:0]  org_col;
    pixel_t            lb_rd  [K-1];
    pixel_t            new_col[K];

    // A pending window blocks new pixels only if it is not being taken this cycle.
    assign in_ready_o = (state_q == RUN) && (!win_valid_q || win_ready_i);
    assign accept     = in_valid_i && in_ready_o;
    assign last_px    = (row_q == h_last_q) && (col_q == w_last_q);
    assign org_row    = row_q - ROW_W'(K - 1);
    assign org_col    = col_q - COL_W'(K - 1);

    // Columns c < K-1 still hold the tail of the previous row, so they never emit.
    always_comb begin
        emit_ok = (row_q >= ROW_W'(K - 1)) && (col_q >= COL_W'(K - 1));
`ifdef CNN_WINGEN_STRIDE2_EN
        if (stride2_q && (org_row[0] || org_col[0])) begin
            emit_ok = 1'b0;
        end
`endif
    end

    // Raster counters; both wrap to zero after the final pixel.
    always_comb begin
        col_d = col_q + COL_W'(1);
        row_d = row_q;
        if (col_q == w_last_q) begin
            col_d = '0;
            row_d = (row_q == h_last_q) ? '0 : row_q + ROW_W'(1);
        end
    end

    // Line buffer 0 holds row r-1, buffer K-2 holds row r-K+1; each one
    // passes its old value up to the next on every accepted pixel.
    for (genvar g = 0; g < K - 1; g++) begin : g_lb
        pixel_t wd;
        if (g == 0) begin : g_first
            assign wd = in_data_i;
        end else begin : g_rest
            assign wd = lb_rd[g-1];
        end
        cnn_line_buffer u_lb (
            .clk_i  (clk_i),
            .we_i   (accept),
            .addr_i (col_q),
            .wdat_i (wd),
            .rdat_o (lb_rd[g])
        );
    end

    // Incoming right-hand column, top (oldest row) to bottom (current pixel).
    always_comb begin
        new_col[K-1] = in_data_i;
        for (int i = 0; i < K - 1; i++) begin
            new_col[i] = lb_rd[K-2-i];
        end
    end

    always_comb begin
        win_data_o = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                win_data_o[(i*K+j)*DATA_W +: DATA_W] = win_q[i][j];
            end
        end
    end

    assign win_valid_o = win_valid_q;
    assign win_row_o   = win_row_q;
    assign win_col_o   = win_col_q;
    assign done_o      = done_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            h_last_q    <= '0;
            w_last_q    <= '0;
            win_valid_q <= 1'b0;
            win_row_q   <= '0;
            win_col_q   <= '0;
            done_q      <= 1'b0;
`ifdef CNN_WINGEN_STRIDE2_EN
            stride2_q   <= 1'b0;
`endif
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K; j++) begin
                    win_q[i][j] <= '0;
                end
            end
        end else begin
            done_q <= 1'b0;
            if (win_valid_q && win_ready_i) begin
                win_valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        w_last_q <= last_col(img_w_i);
                        h_last_q <= last_row(img_h_i);
                        row_q    <= '0;
                        col_q    <= '0;
`ifdef CNN_WINGEN_STRIDE2_EN
                        stride2_q <= cfg_stride2_i;
`endif
                        state_q  <= RUN;
                    end
                end

                RUN: begin
                    if (accept) begin
                        for (int i = 0; i < K; i++) begin
                            for (int j = 0; j < K - 1; j++) begin
                                win_q[i][j] <= win_q[i][j+1];
                            end
                            win_q[i][K-1] <= new_col[i];
                        end
                        row_q <= row_d;
                        col_q <= col_d;
                        // Overrides the handshake clear above when a new window loads.
                        if (emit_ok) begin
                            win_valid_q <= 1'b1;
                            win_row_q   <= org_row;
                            win_col_q   <= org_col;
                        end
                        if (last_px) begin
                            state_q <= FLUSH;
                        end
                    end
                end

                FLUSH: begin
                    if (!win_valid_q || win_ready_i) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_window_gen.sv
// Scoreboard bench for cnn_window_gen: driver pushes expected windows as pixels are issued,
// a negedge monitor pops and compares on each window handshake and checks held output while stalled.
// Covers reset state, 5x5, 8x6 (free-running and random backpressure), mid-frame reset,
// start during RUN, dimension clamping and (with CNN_WINGEN_STRIDE2_EN) stride-2 9x9.
module tb_cnn_window_gen;
    import cnn_pkg::*;

    localparam int WD = K * K * DATA_W;

    logic                 clk_i = 1'b0;
    logic                 rst_ni = 1'b0;
    logic                 start_i = 1'b0;
    logic [DIM_W_W-1:0]   img_w_i = '0;
    logic [DIM_H_W-1:0]   img_h_i = '0;
`ifdef CNN_WINGEN_STRIDE2_EN
    logic                 cfg_stride2_i = 1'b0;
`endif
    logic                 in_valid_i = 1'b0;
    logic                 in_ready_o;
    logic [DATA_W-1:0]    in_data_i = '0;
    logic                 win_valid_o;
    logic                 win_ready_i = 1'b0;
    logic [WD-1:0]        win_data_o;
    logic [ROW_W-1:0]     win_row_o;
    logic [COL_W-1:0]     win_col_o;
    logic                 done_o;

    cnn_window_gen dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .img_w_i     (img_w_i),
        .img_h_i     (img_h_i),
`ifdef CNN_WINGEN_STRIDE2_EN
        .cfg_stride2_i (cfg_stride2_i),
`endif
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .win_valid_o (win_valid_o),
        .win_ready_i (win_ready_i),
        .win_data_o  (win_data_o),
        .win_row_o   (win_row_o),
        .win_col_o   (win_col_o),
        .done_o      (done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [WD-1:0]    d;
        logic [ROW_W-1:0] r;
        logic [COL_W-1:0] c;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   n_win = 0;
    int   n_done = 0;
    int   last_hs_cyc = 0;
    int   done_cyc = 0;
    int   first_acc = 0;
    int   last_acc = 0;
    int   ready_mode = 0;   // 0: always ready, 1: random 50%

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(posedge clk_i) begin
        #1;
        win_ready_i = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end

    task automatic chk_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic chk_vec(input string name, input logic [WD-1:0] act, input logic [WD-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Ramp frame: pixel(r,c) = r*16 + c.
    function automatic logic [WD-1:0] ramp_win(input int r0, input int c0);
        logic [WD-1:0] w;
        w = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                w[(i*K+j)*DATA_W +: DATA_W] = 16'((r0 + i) * 16 + (c0 + j));
            end
        end
        return w;
    endfunction

    // Monitor: compare on handshake, and check the held output against the front entry while stalled.
    always @(negedge clk_i) begin
        exp_t e;
        if (rst_ni) begin
            if (win_valid_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_window actual=(%0d,%0d) required=none", win_row_o, win_col_o);
                end else begin
                    e = exp_q[0];
                    chk_vec(win_ready_i ? "win_data" : "stall_data", win_data_o, e.d);
                    chk_int(win_ready_i ? "win_origin" : "stall_origin",
                            int'({win_row_o, win_col_o}), int'({e.r, e.c}));
                    if (win_ready_i) begin
                        void'(exp_q.pop_front());
                        n_win++;
                        last_hs_cyc = cyc;
                    end
                end
            end
            if (done_o) begin
                n_done++;
                done_cyc = cyc;
            end
        end
    end

    task automatic send_pixel(input logic [DATA_W-1:0] d);
        int  n;
        logic acc;
        n = 0;
        acc = 1'b0;
        in_valid_i = 1'b1;
        in_data_i  = d;
        while (!acc) begin
            @(negedge clk_i);
            acc = in_ready_o;
            if (acc) last_acc = cyc;
            @(posedge clk_i);
            #1;
            n++;
            if (!acc && n > 200) begin
                checks++;
                errors++;
                $display("FAIL pixel_accept_timeout actual=stalled required=accepted");
                break;
            end
        end
        in_valid_i = 1'b0;
    endtask

    task automatic pulse_start(input int w, input int h, input bit s2);
        start_i = 1'b1;
        img_w_i = DIM_W_W'(w);
        img_h_i = DIM_H_W'(h);
`ifdef CNN_WINGEN_STRIDE2_EN
        cfg_stride2_i = s2;
`endif
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
    endtask

    // Issue a ramp frame of we x he pixels; stop early after max_px pixels when max_px >= 0.
    // inj_at >= 0 holds a conflicting start request high while that pixel is offered.
    task automatic send_frame(input int we, input int he, input bit s2, input int max_px, input int inj_at);
        int idx;
        exp_t e;
        idx = 0;
        for (int r = 0; r < he; r++) begin
            for (int c = 0; c < we; c++) begin
                if (max_px >= 0 && idx >= max_px) return;
                if (r >= K - 1 && c >= K - 1 &&
                    (!s2 || (((r - K + 1) % 2 == 0) && ((c - K + 1) % 2 == 0)))) begin
                    e.d = ramp_win(r - K + 1, c - K + 1);
                    e.r = ROW_W'(r - K + 1);
                    e.c = COL_W'(c - K + 1);
                    exp_q.push_back(e);
                end
                if (idx == inj_at) begin
                    start_i = 1'b1;
                    img_w_i = DIM_W_W'(K);
                    img_h_i = DIM_H_W'(K);
                end
                send_pixel(16'(r * 16 + c));
                start_i = 1'b0;
                if (idx == 0) first_acc = last_acc;
                idx++;
            end
        end
    endtask

    task automatic run_frame(input string tag, input int wc, input int hc, input int we, input int he,
                             input bit s2, input int inj_at, input int exp_n,
                             input bit chk_lat, input bit chk_bub);
        int w0;
        int d0;
        int n;
        w0 = n_win;
        d0 = n_done;
        pulse_start(wc, hc, s2);
        send_frame(we, he, s2, -1, inj_at);
        n = 0;
        while (n_done == d0 && n < 400) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        if (n_done == d0) begin
            checks++;
            errors++;
            $display("FAIL %s done_timeout actual=no_done required=done", tag);
        end
        repeat (3) @(posedge clk_i);
        #1;
        chk_int({tag, "_win_count"}, n_win - w0, exp_n);
        chk_int({tag, "_done_count"}, n_done - d0, 1);
        chk_int({tag, "_queue_left"}, exp_q.size(), 0);
        if (chk_lat) chk_int({tag, "_done_latency"}, done_cyc - last_hs_cyc, 1);
        if (chk_bub) chk_int({tag, "_accept_span"}, last_acc - first_acc, we * he - 1);
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk_int({tag, "_in_ready"}, int'(in_ready_o), 0);
        chk_int({tag, "_win_valid"}, int'(win_valid_o), 0);
        chk_int({tag, "_done"}, int'(done_o), 0);
        chk_vec({tag, "_win_data"}, win_data_o, '0);
        chk_int({tag, "_win_origin"}, int'({win_row_o, win_col_o}), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check_reset_outputs("reset");
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // 5x5: single window, done one cycle after it
        ready_mode = 0;
        run_frame("t1_5x5", 5, 5, 5, 5, 1'b0, -1, 1, 1'b1, 1'b0);

        // 8 wide x 6 high: 8 windows, no bubbles
        run_frame("t2_8x6", 8, 6, 8, 6, 1'b0, -1, 8, 1'b0, 1'b1);

        // Same frame under random backpressure
        ready_mode = 1;
        run_frame("t3_8x6_bp", 8, 6, 8, 6, 1'b0, -1, 8, 1'b0, 1'b0);
        ready_mode = 0;

        // Abort after 20 pixels, then a full frame
        pulse_start(8, 6, 1'b0);
        send_frame(8, 6, 1'b0, 20, -1);
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("t4_abort");
        exp_q.delete();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        run_frame("t4_after_abort", 8, 6, 8, 6, 1'b0, -1, 8, 1'b0, 1'b0);

        // Conflicting start during RUN must be ignored
        run_frame("t5_restart", 8, 6, 8, 6, 1'b0, 10, 8, 1'b0, 1'b0);

        // Out-of-range dimensions clamp: width 2 -> 5, height 40 -> 32
        run_frame("t7_clamp", 2, 40, 5, 32, 1'b0, -1, 28, 1'b0, 1'b0);

`ifdef CNN_WINGEN_STRIDE2_EN
        // Stride 2 on 9x9: origins {0,2,4} x {0,2,4}
        run_frame("t6_stride2", 9, 9, 9, 9, 1'b1, -1, 9, 1'b0, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
